// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm_if
// ----------------------------------------------------------------------------
// Groups the signals between the cache miss-fill controller, the cache arrays
// and pipelined main memory.
//
//   master (fill controller):
//     in : miss_detected, miss_address, memory_data_valid, memory_data
//     out: fsm_busy, mem_req, memory_address, cache_addr, cache_data,
//          write_data_array, write_tag_array
//   slave (cache + memory side): the mirror image of master.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);
  // Cache -> controller
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  // Memory -> controller
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  // Controller -> requester / memory / cache arrays
  logic                  fsm_busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [15:0]           cache_data;
  logic                  write_data_array;
  logic                  write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output mem_req,
    output memory_address,
    output cache_addr,
    output cache_data,
    output write_data_array,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  mem_req,
    input  memory_address,
    input  cache_addr,
    input  cache_data,
    input  write_data_array,
    input  write_tag_array
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm
// ----------------------------------------------------------------------------
// Miss-handling controller in front of the 2-way cache data/meta arrays.
// On a miss it requests every word of the block from pipelined memory on
// consecutive cycles, streams each returned word into the data array, then
// commits the block with a single tag/meta write. The requester is stalled
// (fsm_busy) for the whole transfer.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - cache_fill_fsm_if.master
//          miss_detected/miss_address      : miss report from the cache
//          memory_data_valid/memory_data   : returned memory words
//          fsm_busy                        : fill in progress
//          mem_req/memory_address          : memory read request
//          cache_addr/cache_data           : data/meta array address, data
//          write_data_array                : data-array write strobe
//          write_tag_array                 : meta-array write strobe
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8    // power of 2, at least 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cache_fill_fsm_if.master  bus
);

  // Counter width holds 0..WORDS_PER_BLOCK inclusive, so the request counter
  // can park at WORDS_PER_BLOCK once all requests are out.
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
  // Byte-offset width inside a block (2 bytes per word). Equal to CNT_W.
  localparam int OFF_W = $clog2(2 * WORDS_PER_BLOCK);

  localparam logic [CNT_W-1:0] WORDS    = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      recv_cnt_q,  recv_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q,      base_d;

  // Offset bits of the miss address never matter: the block is fetched from
  // its first word regardless of which word missed.
  logic w_unused_offset;
  assign w_unused_offset = ^bus.miss_address[OFF_W-1:0];

  // Word address inside the current block. The offset is substituted rather
  // than added, so the tag/set field of base_q can never be disturbed.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [CNT_W-2:0] idx
  );
    return {base_q[ADDR_WIDTH-1:OFF_W], idx, 1'b0};
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  // Busy is a pure decode of the state register so it drops at once on reset.
  assign bus.fsm_busy = (state_q != ST_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d              = state_q;
    issue_cnt_d          = issue_cnt_q;
    recv_cnt_d           = recv_cnt_q;
    base_d               = base_q;

    bus.mem_req          = 1'b0;
    bus.memory_address   = '0;
    bus.cache_addr       = '0;
    bus.cache_data       = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Returned-data strobes are ignored here: stale pulses after an
        // aborted fill must not write anything.
        if (bus.miss_detected) begin
          state_d     = ST_FETCH;
          base_d      = {bus.miss_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end

      ST_FETCH: begin
        // Request side: one request per cycle, no memory back-pressure.
        if (issue_cnt_q < WORDS) begin
          bus.mem_req        = 1'b1;
          bus.memory_address = word_addr(issue_cnt_q[CNT_W-2:0]);
          issue_cnt_d        = issue_cnt_q + CNT_ONE;
        end

        // Return side: independent of the request side, may overlap it.
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.cache_addr       = word_addr(recv_cnt_q[CNT_W-2:0]);
          bus.cache_data       = bus.memory_data;
          recv_cnt_d           = recv_cnt_q + CNT_ONE;
          if (recv_cnt_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end
        end
      end

      ST_COMMIT: begin
        // The cache keeps miss_detected high while the meta write happens,
        // so the miss is deliberately not examined here.
        bus.write_tag_array = 1'b1;
        bus.cache_addr      = base_q;
        state_d             = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// tb_cache_fill_fsm
// ----------------------------------------------------------------------------
// Directed self-checking bench for cache_fill_fsm. Inputs are driven on the
// falling edge and outputs compared 1 ns later, away from the active edge.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_WIDTH(AW)) bus ();

  cache_fill_fsm #(
    .ADDR_WIDTH      (AW),
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares all outputs. Address/data fields are only compared when they are
  // defined (request/write active), or always when 'full' is set (IDLE/reset,
  // where every output must be 0).
  task automatic expect_outs(input string tag, input bit full,
                             input logic busy, input logic req,
                             input logic [15:0] maddr, input logic wda,
                             input logic [15:0] caddr, input logic [15:0] cdata,
                             input logic wta);
    chk({tag, ".busy"}, 32'(bus.fsm_busy), 32'(busy));
    chk({tag, ".req"},  32'(bus.mem_req), 32'(req));
    chk({tag, ".wda"},  32'(bus.write_data_array), 32'(wda));
    chk({tag, ".wta"},  32'(bus.write_tag_array), 32'(wta));
    if (full || req)
      chk({tag, ".maddr"}, 32'(bus.memory_address), 32'(maddr));
    if (full || wda || wta)
      chk({tag, ".caddr"}, 32'(bus.cache_addr), 32'(caddr));
    if (full || wda)
      chk({tag, ".cdata"}, 32'(bus.cache_data), 32'(cdata));
  endtask

  // One complete fill. The first cycle is an IDLE cycle presenting the miss;
  // memory returns word k = 0x1000+k, the request issued in FETCH cycle f
  // returning in cycle f+lat, with an optional gap of gap_len invalid cycles
  // once gap_after words have been received. During FETCH the miss address
  // is replaced by 'noise'. Ends after checking the COMMIT cycle.
  task automatic fill(input string tag, input logic [15:0] maddr,
                      input logic [15:0] noise, input int lat,
                      input int gap_after, input int gap_len,
                      input int exp_cycles);
    logic [15:0] base;
    logic        v;
    int          k;
    int          f;
    int          gap_cnt;
    base = {maddr[15:4], 4'h0};

    @(negedge clk);
    bus.miss_detected     = 1'b1;
    bus.miss_address      = maddr;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;
    #1;
    expect_outs({tag, ".accept"}, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);

    k = 0; f = 0; gap_cnt = 0;
    while (k < 8 && f < 64) begin
      @(negedge clk);
      bus.miss_address = noise;
      v = 1'b0;
      if (f >= lat) begin
        if (k == gap_after && gap_cnt < gap_len) gap_cnt++;
        else v = 1'b1;
      end
      bus.memory_data_valid = v;
      bus.memory_data       = v ? (16'h1000 + 16'(k)) : 16'hDEAD;
      #1;
      expect_outs($sformatf("%s.f%0d", tag, f), 1'b0, 1'b1, (f < 8),
                  base + 16'(2 * f), v, base + 16'(2 * k),
                  16'h1000 + 16'(k), 1'b0);
      if (v) k++;
      f++;
    end
    chk({tag, ".words"}, 32'(k), 32'd8);
    chk({tag, ".fetch_cycles"}, 32'(f), 32'(exp_cycles));

    // COMMIT: a stray valid here must not produce a data write.
    @(negedge clk);
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    #1;
    expect_outs({tag, ".commit"}, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, base, 16'h0, 1'b1);
  endtask

  // IDLE cycles with no miss and memory_data_valid pulsing.
  task automatic idle_noise(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'h7777;
      #1;
      expect_outs($sformatf("%s.%0d", tag, i), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0,
                  16'h0, 16'h0, 1'b0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h3A76;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'h5555;

    // Reset held with active inputs: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      expect_outs($sformatf("reset.%0d", i), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0,
                  16'h0, 16'h0, 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b1;

    // Basic fill, latency 4: returns in FETCH cycles 4..11.
    fill("basic", 16'h3A76, 16'h3A76, 4, 8, 0, 12);
    idle_noise("idle_a", 2);

    // Three-cycle gap between the 4th and 5th words.
    fill("gap", 16'h1234, 16'h1234, 4, 4, 3, 15);
    idle_noise("idle_b", 1);

    // Back-to-back: second miss presented in the first IDLE after COMMIT.
    fill("b2b_a", 16'h0010, 16'h0010, 4, 8, 0, 12);
    fill("b2b_b", 16'hFFF2, 16'hFFF2, 4, 8, 0, 12);

    // Miss address changes during FETCH; then valid pulses in IDLE.
    fill("noise", 16'h5A5C, 16'hC3C3, 2, 8, 0, 10);
    idle_noise("idle_c", 4);

    // Reset after 3 of 8 words have been written.
    @(negedge clk);
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h0100;
    bus.memory_data_valid = 1'b0;
    #1;
    expect_outs("abort.accept", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      bus.memory_data_valid = (f >= 1);
      bus.memory_data       = 16'h1000 + 16'(f - 1);
      #1;
      expect_outs($sformatf("abort.f%0d", f), 1'b0, 1'b1, 1'b1,
                  16'h0100 + 16'(2 * f), (f >= 1), 16'h0100 + 16'(2 * (f - 1)),
                  16'h1000 + 16'(f - 1), 1'b0);
    end
    @(negedge clk);
    rst                   = 1'b0;
    bus.memory_data_valid = 1'b1;
    #1;
    expect_outs("abort.rst_now", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.miss_detected = 1'b0;
      #1;
      expect_outs($sformatf("abort.rst%0d", i), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0,
                  16'h0, 16'h0, 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    idle_noise("abort.stale", 3);

    // Restart of the aborted block begins again at word 0.
    fill("restart", 16'h0100, 16'h0100, 1, 8, 0, 9);

    @(negedge clk);
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    #1;
    expect_outs("final_idle", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller directly upstream of the 2-way cache data/meta arrays.
- On a cache miss it fetches the whole 16-byte block (8 x 16-bit words) from pipelined main memory and streams each returned word into the cache data array.
- After the last word it issues a single tag/meta write, which commits the block and clears the miss.
- It holds the pipeline stalled (fsm_busy) for the whole transfer.

Parameters:
- ADDR_WIDTH, 16, byte address width of miss and memory addresses.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block. Must be a power of 2; block = 2*WORDS_PER_BLOCK bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- miss_detected  input  1  cache reports a miss on miss_address.
- miss_address  input  ADDR_WIDTH  byte address that missed.
- memory_data_valid  input  1  memory_data holds a returned word this cycle.
- memory_data  input  16  word returned by memory.
- fsm_busy  output  1  fill in progress; stall the requester.
- mem_req  output  1  read request to memory this cycle.
- memory_address  output  ADDR_WIDTH  byte address of the current request.
- cache_addr  output  ADDR_WIDTH  byte address of the word being written into the cache.
- cache_data  output  16  data written into the cache (equals memory_data).
- write_data_array  output  1  drives the cache data-array write (data_wr).
- write_tag_array  output  1  drives the cache meta write (wr).

Behaviour:
- States:
  - IDLE: wait for a miss.
  - FETCH: issue requests and collect words.
  - COMMIT: single-cycle tag write.
- State register is async-cleared by rst low to IDLE. issue_cnt, recv_cnt and base_addr also clear to 0.
- Output values:
  - All outputs are 0 during reset and in IDLE.
  - fsm_busy = (state != IDLE), decoded from state.
- IDLE -> FETCH:
  - Taken on a rising clk edge with miss_detected=1.
  - base_addr latches {miss_address[ADDR_WIDTH-1:4], 4'b0} (block aligned).
  - Both counters clear.
  - fsm_busy rises the cycle after the miss is first seen.
- FETCH, request side:
  - mem_req=1 while issue_cnt < WORDS_PER_BLOCK.
  - memory_address = base_addr + 2*issue_cnt.
  - issue_cnt increments every cycle while mem_req=1.
  - Exactly 8 requests go out on 8 consecutive cycles. No back-pressure is taken from memory.
- FETCH, return side:
  - On memory_data_valid=1: write_data_array=1, cache_addr = base_addr + 2*recv_cnt, cache_data = memory_data. recv_cnt increments.
  - All three of these outputs are combinational on memory_data_valid in the same cycle.
  - The return side runs independently of the request side; returns may overlap issuing.
  - memory_data_valid=0 -> write_data_array=0. cache_addr/cache_data don't care.
- FETCH -> COMMIT: on the edge where memory_data_valid=1 and recv_cnt == WORDS_PER_BLOCK-1, i.e. the 8th word is written.
- COMMIT:
  - write_tag_array=1 for exactly one cycle, with cache_addr = base_addr and write_data_array=0.
  - Next state is IDLE unconditionally. miss_detected is ignored in COMMIT, because the cache holds miss high during wr.
- Next miss:
  - The first IDLE cycle after COMMIT may accept a new miss.
  - A miss_detected that is still high in that cycle starts a new fill; the cache must have dropped it for a hit.
- Ignored inputs:
  - memory_data_valid in IDLE or COMMIT is ignored: no write, no counter change.
  - miss_detected and miss_address changes during FETCH are ignored; base_addr is frozen.
- Counter widths and overflow:
  - Both counters are log2(WORDS_PER_BLOCK)+1 bits.
  - Address arithmetic is unsigned and uses only the low 4 offset bits, so it never carries into the tag/set field.
- Minimum fill latency from miss: 1 (accept) + memory latency + 8 (returns) + 1 (COMMIT).
- rst low mid-fill: immediate return to IDLE with all outputs 0. The partially written block stays invalid because no tag write occurred. Later stale valid pulses are ignored in IDLE.

Test Plan:
- Reset: hold rst=0 with miss_detected=1 and memory_data_valid=1 -> every output is 0 and state stays IDLE. After release the next edge starts a fill.
- Basic fill, memory latency 4: miss at 0x3A76, memory returns word k=0x1000+k.
  - mem_req is high 8 cycles, memory_address runs 0x3A70..0x3A7E step 2.
  - write_data_array pulses 8 times with cache_addr 0x3A70..0x3A7E and matching data.
  - write_tag_array pulses once, the cycle after the last word.
  - fsm_busy is high throughout, then low.
- Gapped returns: memory_data_valid deasserted for 3 cycles between words 4 and 5 -> no spurious writes, recv_cnt holds, commit occurs only after the 8th valid.
- Back-to-back misses: miss 0x0010 then, the first IDLE cycle after COMMIT, miss 0xFFF2 -> second fill uses base 0xFFF0 and addresses wrap within the block only (0xFFF0..0xFFFE).
- Noise: change miss_address during FETCH, and pulse memory_data_valid in IDLE -> base address is unchanged and no writes occur in IDLE.
- Reset mid-fill after 3 words -> write_tag_array never asserts, outputs are 0 at once, a new miss restarts from word 0.
